// File: rtl/pisca_monitor.sv
// Receive-side blink monitor: synchronizes an asynchronous blink input and reports
// its period, high time and blink count, and flags a stuck (non-toggling) input.
module pisca_monitor #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pis,
  output logic             level,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             stuck,
  output logic [7:0]       blinks
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] MEAS = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);

  // state is kept as a named internal signal so checkers can bind to it
  logic [0:0]       state;
  logic             s1, s2, s3;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hi_hold;
  logic             rise;
  logic             fall;
  logic             timeout;

  assign level   = s2;
  assign rise    = s2 & ~s3;
  assign fall    = ~s2 & s3;
  assign timeout = (cnt >= TO_VAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= pis;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // cnt holds the number of cycles since the last rise, saturating at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (rise) begin
      cnt <= CNT_W'(1);
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      hi_hold      <= '0;
      period       <= '0;
      high_time    <= '0;
      period_valid <= 1'b0;
      stuck        <= 1'b0;
      blinks       <= 8'd0;
    end else begin
      period_valid <= 1'b0;
      if (rise) begin
        // a rise always wins over a coincident timeout
        stuck  <= 1'b0;
        blinks <= blinks + 8'd1;
        if (state == MEAS) begin
          period       <= cnt;
          high_time    <= hi_hold;
          period_valid <= 1'b1;
        end
        state <= MEAS;
      end else begin
        if (fall && (state == MEAS)) begin
          hi_hold <= cnt;
        end
        if (timeout) begin
          stuck <= 1'b1;
          state <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_pisca_monitor.sv
// Bench for pisca_monitor: directed and random blink waveforms compared each cycle
// against an edge-history reference model.
module tb_pisca_monitor;

  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 100;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             pis;
  logic             level;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             period_valid;
  logic             stuck;
  logic [7:0]       blinks;

  pisca_monitor #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pis          (pis),
    .level        (level),
    .period       (period),
    .high_time    (high_time),
    .period_valid (period_valid),
    .stuck        (stuck),
    .blinks       (blinks)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;

  // reference model: pis samples per clock edge since reset, and the edge index
  // of the last detected rise; elapsed cycles come from plain index arithmetic
  bit hist[$];
  int m;
  int r;
  bit meas;
  int m_period, m_high, m_hold, m_blinks;
  bit m_stuck, m_pv;

  function automatic bit h(input int n);
    if (n < 1) return 1'b0;
    return hist[n-1];
  endfunction

  task automatic model_reset();
    hist.delete();
    m = 0;
    r = 1;
    meas = 1'b0;
    m_period = 0; m_high = 0; m_hold = 0; m_blinks = 0;
    m_stuck = 1'b0; m_pv = 1'b0;
  endtask

  task automatic model_edge();
    bit rs, fl;
    int el;
    rs = h(m-2) && !h(m-3);
    fl = !h(m-2) && h(m-3);
    el = m - r;
    if (el > CNT_MAX) el = CNT_MAX;
    m_pv = 1'b0;
    if (rs) begin
      if (meas) begin
        m_period = el;
        m_high   = m_hold;
        m_pv     = 1'b1;
      end
      meas     = 1'b1;
      m_stuck  = 1'b0;
      m_blinks = (m_blinks + 1) % 256;
      r        = m;
    end else begin
      if (fl && meas) m_hold = el;
      if (el >= TIMEOUT) begin
        m_stuck = 1'b1;
        meas    = 1'b0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, m);
    end
  endtask

  task automatic check_all();
    chk("level", 32'(level), 32'(h(m-1)));
    chk("period_valid", 32'(period_valid), 32'(m_pv));
    chk("period", 32'(period), 32'(m_period));
    chk("high_time", 32'(high_time), 32'(m_high));
    chk("stuck", 32'(stuck), 32'(m_stuck));
    chk("blinks", 32'(blinks), 32'(m_blinks));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_level"}, 32'(level), 0);
    chk({tag, "_period"}, 32'(period), 0);
    chk({tag, "_high_time"}, 32'(high_time), 0);
    chk({tag, "_period_valid"}, 32'(period_valid), 0);
    chk({tag, "_stuck"}, 32'(stuck), 0);
    chk({tag, "_blinks"}, 32'(blinks), 0);
  endtask

  // driver tasks
  task automatic tick(input bit p);
    pis = p;
    @(posedge clk);
    m++;
    hist.push_back(p);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic wave(input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      repeat (hi) tick(1'b1);
      repeat (lo) tick(1'b0);
    end
  endtask

  // assert reset between clock edges, hold it with pis toggling, release mid-cycle
  task automatic async_reset(input int cycles);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("rst_async");
    for (int i = 0; i < cycles; i++) begin
      pis = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check_zero("rst_hold");
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    pis   = 1'b0;
    rst_n = 1'b1;
    model_reset();
    #1;
    rst_n = 1'b0;
    #1;
    check_zero("por");
    for (int i = 0; i < 5; i++) begin
      pis = 1'(i & 1);
      @(posedge clk);
      #1;
      check_zero("por_hold");
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // first rise after reset: counted, but no period reported
    repeat (3) tick(1'b0);
    repeat (4) tick(1'b1);
    chk("first_blinks", 32'(blinks), 1);
    chk("first_period", 32'(period), 0);
    repeat (6) tick(1'b1);
    repeat (10) tick(1'b0);

    // square wave 10/10
    wave(10, 10, 4);
    chk("sq_period", 32'(period), 20);
    chk("sq_high", 32'(high_time), 10);

    // asymmetric duty, then a change of duty
    wave(3, 13, 3);
    chk("asym_period", 32'(period), 16);
    chk("asym_high", 32'(high_time), 3);
    wave(7, 5, 3);
    chk("asym2_period", 32'(period), 12);
    chk("asym2_high", 32'(high_time), 7);

    // stuck low long enough to also saturate the counter
    wave(10, 10, 2);
    repeat (10) tick(1'b1);
    repeat (300) tick(1'b0);
    chk("stuck_set", 32'(stuck), 1);
    chk("stuck_hold_period", 32'(period), 20);
    wave(10, 10, 3);
    chk("stuck_clear", 32'(stuck), 0);
    chk("after_stuck_period", 32'(period), 20);

    // boundary: rise exactly at the timeout, and one cycle past it
    wave(50, 50, 3);
    chk("to_edge_period", 32'(period), TIMEOUT);
    wave(50, 51, 2);
    wave(10, 10, 2);

    // random duty cycles, occasionally long enough to time out
    for (int i = 0; i < 40; i++) begin
      wave($urandom_range(2, 40), $urandom_range(2, (i % 8 == 7) ? 120 : 40), 1);
    end

    // async reset in the middle of a measurement
    wave(10, 10, 2);
    repeat (5) tick(1'b1);
    async_reset(3);
    repeat (2) tick(1'b0);
    wave(10, 10, 3);
    chk("rst_mid_period", 32'(period), 20);
    chk("rst_mid_blinks", 32'(blinks), 3);

    // blink counter wrap
    async_reset(2);
    wave(2, 2, 256);
    chk("wrap_zero", 32'(blinks), 0);
    wave(2, 2, 1);
    chk("wrap_one", 32'(blinks), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pisca_monitor.md
# pisca_monitor

Receive-side companion to the blink generator: samples an asynchronous blink signal `pis` into the `clk` domain and measures it. Reports the period and high time in `clk` cycles, counts blinks, and flags a stuck (non-toggling) input. It sits at the consuming end of any `pis` line, whether a board LED net or a generator output routed back for self-check.

## Interface
Parameters:
- `CNT_W`, default 16: width of the period and high-time counters.
- `TIMEOUT`, default 1000: number of cycles without a rising edge before `stuck` asserts. Must satisfy 2 ≤ TIMEOUT < 2^CNT_W − 1.

Ports:
- `clk`  in  1  sole clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `pis`  in  1  blink input, asynchronous to `clk`.
- `level`  out  1  synchronized level of `pis`.
- `period`  out  CNT_W  cycles between the last two rising edges.
- `high_time`  out  CNT_W  cycles from a rising edge to the following falling edge, for the last complete period.
- `period_valid`  out  1  one-cycle pulse when `period` and `high_time` update.
- `stuck`  out  1  no rising edge for ≥ TIMEOUT cycles.
- `blinks`  out  8  count of rising edges; wraps.

## Operation
- **Synchronizer and edge detect.** Three flops: s1 ← pis, s2 ← s1, s3 ← s2. `level` = s2. rise = s2 & ~s3; fall = ~s2 & s3.
- **Cycle counter `cnt`** (CNT_W bits):
  - cnt ← 1 on rise.
  - Otherwise cnt increments each cycle, saturating at 2^CNT_W − 1.
  - At a rise, cnt equals the number of cycles since the previous rise.
- **State machine.** States are IDLE and MEAS; reset state is IDLE.
  - IDLE, on rise: go to MEAS. No `period_valid`, because no reference edge exists yet.
  - MEAS, on fall: hi_hold ← cnt.
  - MEAS, on rise: period ← cnt, high_time ← hi_hold, period_valid ← 1. Stay in MEAS.
  - MEAS, no rise and cnt ≥ TIMEOUT: go to IDLE.
- **Stuck flag.**
  - stuck ← 1 when cnt ≥ TIMEOUT and no rise. This applies in either state, including after reset with `pis` never toggling.
  - stuck ← 0 on rise.
- **Blink counter.** blinks ← blinks + 1 on every rise, including the first after reset or stuck. Wraps 255 → 0.
- **Simultaneous events.**
  - Rise and timeout in the same cycle: the rise wins. The period is reported if in MEAS (period may equal TIMEOUT), stuck clears, and state stays MEAS.
  - Rise and fall cannot coincide.
- **Edge cases.**
  - A fall seen in IDLE is ignored (hi_hold is not updated).
  - `period` and `high_time` hold their last values until the next valid rise, including while `stuck` = 1.
- **Reset.** `rst_n` low clears everything immediately, without a clock edge: s1–s3, cnt, hi_hold, state = IDLE, and all outputs = 0. The first period after reset release is never reported.

## Timing
- All outputs are registered except `level`, which is s2 (a flop output).
- Rising edge of `pis` first sampled high at clock edge k:
  - `level` rises after edge k+1.
  - rise is true during cycle k+1..k+2.
  - `period_valid`, `period`, `high_time`, and `blinks` update at edge k+2.
  - `period_valid` is high for exactly one cycle, edge k+2 to k+3.
- Minimum measurable pulse: `pis` must be stable for ≥ 2 `clk` cycles per level. Shorter pulses may be missed; this is not required to be detected.
- `stuck` rises at the edge where cnt has reached TIMEOUT: TIMEOUT+1 cycles after the rise edge's update.
- Reset release: the first sample of `pis` occurs at the first `clk` edge with `rst_n` high.

## Test plan
- **Reset behaviour.** Hold rst_n = 0 for 5 cycles with `pis` toggling → all outputs 0. Release, then first rising edge → blinks = 1, no period_valid, period = 0.
- **Square wave.** `pis` 10 cycles high / 10 low, 4 periods → period_valid pulses 1 cycle wide, 20 cycles apart, starting at the second rise. period = 20, high_time = 10. `level` lags `pis` by 2 cycles.
- **Asymmetric duty.** 3 high / 13 low → period = 16, high_time = 3. Then switch to 7 high / 5 low → the next valid reports period = 12 or a transition value, and the following one reports period = 12, high_time = 7.
- **Stuck.** TIMEOUT = 100. One rise, then `pis` held low → stuck = 1 exactly 101 cycles after the rise update, and period holds its old value. The next rise → stuck = 0, no period_valid. The rise after that (20 cycles later) → period = 20.
- **Wrap.** 256 rising edges from reset → blinks = 0. One more edge → blinks = 1.
- **Async reset mid-measure.** Running 10/10 wave, pull rst_n low between clock edges → outputs go to 0 before the next clk edge. After release → the first rise does not produce period_valid, and the second rise reports period = 20.
